// File: rtl/micro_ucr_nonce_ctrl_if.sv
// rtl/micro_ucr_nonce_ctrl_if.sv - system and hash-core signals of the nonce sequencer
// Signal suffixes are from the controller's point of view; it uses the slave modport.
interface micro_ucr_nonce_ctrl_if;
  logic         start_i;
  logic [95:0]  header_i;
  logic [7:0]   target_i;
  logic         core_done_i;
  logic [23:0]  hash_in_i;
  logic [127:0] block_out_o;
  logic         core_start_o;
  logic         busy_o;
  logic         found_o;
  logic         exhausted_o;
  logic         timeout_o;
  logic [31:0]  nonce_o;
  logic [23:0]  hash_out_o;

  modport slave (
    input  start_i, header_i, target_i, core_done_i, hash_in_i,
    output block_out_o, core_start_o, busy_o, found_o, exhausted_o, timeout_o,
           nonce_o, hash_out_o
  );

  modport master (
    output start_i, header_i, target_i, core_done_i, hash_in_i,
    input  block_out_o, core_start_o, busy_o, found_o, exhausted_o, timeout_o,
           nonce_o, hash_out_o
  );
endinterface

// File: rtl/micro_ucr_nonce_ctrl.sv
// rtl/micro_ucr_nonce_ctrl.sv - nonce-search sequencer driving one micro_ucr_hash core
// Optional WAIT watchdog enabled by defining NONCE_CTRL_TIMEOUT_EN.
module micro_ucr_nonce_ctrl #(
  parameter logic [31:0] NONCE_MAX = 32'hFFFF_FFFF
`ifdef NONCE_CTRL_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 64
`endif
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  micro_ucr_nonce_ctrl_if.slave        bus
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_CHECK} state_e;

  state_e      state_q, state_d;
  logic [95:0] header_q, header_d;
  logic [7:0]  target_q, target_d;
  logic [31:0] nonce_q, nonce_d;
  logic [23:0] hash_q, hash_d;
  logic        busy_q, busy_d;
  logic        found_q, found_d;
  logic        exh_q, exh_d;
  logic        cs_q, cs_d;
  logic        hit;

`ifdef NONCE_CTRL_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wd_q, wd_d;
  logic          to_q, to_d;
`endif

  // Both low hash bytes must be strictly below the target, so target 0 never hits.
  assign hit = (hash_q[7:0] < target_q) && (hash_q[15:8] < target_q);

  always_comb begin
    state_d  = state_q;
    header_d = header_q;
    target_d = target_q;
    nonce_d  = nonce_q;
    hash_d   = hash_q;
    busy_d   = busy_q;
    found_d  = found_q;
    exh_d    = exh_q;
    cs_d     = 1'b0;
`ifdef NONCE_CTRL_TIMEOUT_EN
    wd_d     = wd_q;
    to_d     = to_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          header_d = bus.header_i;
          target_d = bus.target_i;
          nonce_d  = '0;
          busy_d   = 1'b1;
          found_d  = 1'b0;
          exh_d    = 1'b0;
          cs_d     = 1'b1;
          state_d  = S_LAUNCH;
`ifdef NONCE_CTRL_TIMEOUT_EN
          to_d     = 1'b0;
`endif
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
`ifdef NONCE_CTRL_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      S_WAIT: begin
        if (bus.core_done_i) begin
          hash_d  = bus.hash_in_i;
          state_d = S_CHECK;
        end
`ifdef NONCE_CTRL_TIMEOUT_EN
        // The counter holds cycles already spent in WAIT; the abort edge is the TIMEOUT_CYC-th.
        else if (wd_q == CW'(TIMEOUT_CYC - 1)) begin
          to_d    = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      S_CHECK: begin
        if (hit) begin
          found_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (nonce_q == NONCE_MAX) begin
          exh_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          nonce_d = nonce_q + 32'd1;
          cs_d    = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= S_IDLE;
      header_q <= '0;
      target_q <= '0;
      nonce_q  <= '0;
      hash_q   <= '0;
      busy_q   <= 1'b0;
      found_q  <= 1'b0;
      exh_q    <= 1'b0;
      cs_q     <= 1'b0;
`ifdef NONCE_CTRL_TIMEOUT_EN
      wd_q     <= '0;
      to_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      header_q <= header_d;
      target_q <= target_d;
      nonce_q  <= nonce_d;
      hash_q   <= hash_d;
      busy_q   <= busy_d;
      found_q  <= found_d;
      exh_q    <= exh_d;
      cs_q     <= cs_d;
`ifdef NONCE_CTRL_TIMEOUT_EN
      wd_q     <= wd_d;
      to_q     <= to_d;
`endif
    end
  end

  assign bus.block_out_o  = {nonce_q, header_q};
  assign bus.core_start_o = cs_q;
  assign bus.busy_o       = busy_q;
  assign bus.found_o      = found_q;
  assign bus.exhausted_o  = exh_q;
  assign bus.nonce_o      = nonce_q;
  assign bus.hash_out_o   = hash_q;
`ifdef NONCE_CTRL_TIMEOUT_EN
  assign bus.timeout_o    = to_q;
`else
  assign bus.timeout_o    = 1'b0;
`endif

endmodule
